instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts symbolic instruction requests (op class, register fields, immediate, jump target) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word and buffers it in a small FIFO.
- Writes the words sequentially into instruction memory through a handshaked write port.
- Used for program loading and for self-checking benches that round-trip through the control unit.

Parameters:
- DEPTH, 4: FIFO entries (power of two, >=2).
- ADDR_W, 8: instruction-memory word-address width (256 words).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  4  op class: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 BEQ, 7 BNE, 8 LW, 9 SW, 10 ADDI, 11 ORI, 12 J, 13 JAL, 14 NOP, 15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  32  immediate; low 16 bits encoded.
- req_target  in  26  jump word target.
- restart  in  1  flush FIFO, reload address.
- restart_addr  in  ADDR_W  next write address after restart.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts write this cycle.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded word.
- mem_full  out  1  last address written; writing halted.
- err  out  1  one-cycle pulse on illegal/out-of-range request.

Behaviour:
- Reset (rst_n=0 at edge): FIFO empty, imem_addr=0, imem_we=0, imem_wdata=0, mem_full=0, err=0. req_ready is 0 during reset.
- Encoding is combinational on request fields and registered into the FIFO on acceptance:
  - R-type ADD/SUB/AND/OR/SLT: {6'd0, rs, rt, rd, 5'd0, funct}, funct = 32/34/36/37/42.
  - JR: {6'd0, rs, 15'd0, 6'd8}.
  - I-type: {opcode, rs, rt, imm[15:0]}, opcode BEQ=4, BNE=5, LW=35, SW=43, ADDI=8, ORI=13.
  - J-type: {opcode, target}, J=2, JAL=3.
  - NOP: 32'h0.
- req_ready = !fifo_full && !mem_full && !restart.
- Illegal op (15): consumed (ready honoured), nothing enqueued, err=1 for the cycle after acceptance.
- Write side:
  - imem_we = FIFO non-empty && !mem_full. imem_wdata is the FIFO head; imem_addr is the current address.
  - A write completes on a cycle with imem_we && imem_ready: pop FIFO, imem_addr+1.
  - imem_we/addr/data hold stable while imem_ready=0.
- Latency: request accepted at edge N -> imem_we high from cycle N+1 if FIFO was empty. Throughput is 1 word/cycle with imem_ready held 1.
- Full FIFO: a simultaneous pop and push is NOT allowed, because ready was already low that cycle. A push into a non-full FIFO together with a pop is allowed; the count stays the same.
- Wrap: completing a write at address 2^ADDR_W-1 sets mem_full=1 and leaves imem_addr at 2^ADDR_W-1. No wrap to 0. The FIFO contents remain; ready and we stay 0 until restart.
- restart=1 (highest priority after reset): FIFO emptied, imem_addr<=restart_addr, mem_full<=0, any concurrent request not accepted, and any concurrent write completion ignored (no address increment).
- Reset asserted mid-write: the write is abandoned; post-reset state is as above.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined:
  - req_imm must sign-fit 16 bits (ADDI, LW, SW, BEQ, BNE) or zero-extend-fit 16 bits (ORI). Otherwise the request is consumed, not enqueued, and err pulses.
  - R-type requests with rd=0 also raise err but are still enqueued.
- Undefined: req_imm silently truncated to [15:0]; no rd check.

Decomposition:
- Package mips_pkg, shared with ControlUnit: opcode constants (R=0, J=2, JAL=3, BEQ=4, BNE=5, ADDI=8, ORI=13, LW=35, SW=43), funct constants (ADD, SUB, AND, OR, SLT, JR), and req_op class constants.
- Sub-module instr_fifo: synchronous FIFO, parameterised DEPTH/width 32, with push/pop/full/empty/flush.

Test Plan:
- ADDI rs=1 rt=2 imm=5, imem_ready=1 -> one write of 32'h20220005 at addr 0, one cycle after acceptance; addr becomes 1.
- ADD rs=1 rt=2 rd=3 then JAL target=26'h10 -> 32'h00221820 at addr 0, then 32'h0C000010 at addr 1.
- imem_ready=0, push 5 requests with DEPTH=4 -> exactly 4 accepted and req_ready=0. Release imem_ready -> 4 consecutive writes with stable data while stalled.
- restart_addr=8'hFE, push 3 NOPs -> writes to FE and FF, then mem_full=1, third word not written, req_ready=0. Then restart with addr 0 -> FIFO empty, mem_full=0.
- req_op=15 -> no write, err high exactly one cycle. With INSTR_ENC_RANGE_CHECK_EN, ADDI imm=32'h00018000 -> err, no write. Without the macro -> writes imm 16'h8000.
- Reset asserted while imem_we=1 and imem_ready=0 -> next cycle imem_we=0, imem_addr=0, FIFO empty.

Source files
------------

// File: rtl/mips_pkg.sv
// MIPS encoding constants, request op classes and the word encoder shared with the control unit.
package mips_pkg;

   localparam logic [5:0] OPC_R    = 6'd0;
   localparam logic [5:0] OPC_J    = 6'd2;
   localparam logic [5:0] OPC_JAL  = 6'd3;
   localparam logic [5:0] OPC_BEQ  = 6'd4;
   localparam logic [5:0] OPC_BNE  = 6'd5;
   localparam logic [5:0] OPC_ADDI = 6'd8;
   localparam logic [5:0] OPC_ORI  = 6'd13;
   localparam logic [5:0] OPC_LW   = 6'd35;
   localparam logic [5:0] OPC_SW   = 6'd43;

   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;
   localparam logic [5:0] FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37;
   localparam logic [5:0] FN_SLT = 6'd42;
   localparam logic [5:0] FN_JR  = 6'd8;

   typedef enum logic [3:0] {
      OP_ADD     = 4'd0,
      OP_SUB     = 4'd1,
      OP_AND     = 4'd2,
      OP_OR      = 4'd3,
      OP_SLT     = 4'd4,
      OP_JR      = 4'd5,
      OP_BEQ     = 4'd6,
      OP_BNE     = 4'd7,
      OP_LW      = 4'd8,
      OP_SW      = 4'd9,
      OP_ADDI    = 4'd10,
      OP_ORI     = 4'd11,
      OP_J       = 4'd12,
      OP_JAL     = 4'd13,
      OP_NOP     = 4'd14,
      OP_ILLEGAL = 4'd15
   } req_op_e;

   function automatic logic is_alu_rtype(input logic [3:0] op);
      return (op <= OP_SLT);
   endfunction

   // Ops whose immediate is sign-extended by the datapath.
   function automatic logic is_signed_imm(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LW) ||
             (op == OP_SW)  || (op == OP_ADDI);
   endfunction

   function automatic logic [31:0] encode(input logic [3:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [31:0] imm,
                                          input logic [25:0] target);
      logic [31:0] w;
      w = 32'h0;
      case (op)
         OP_ADD:  w = {OPC_R, rs, rt, rd, 5'd0, FN_ADD};
         OP_SUB:  w = {OPC_R, rs, rt, rd, 5'd0, FN_SUB};
         OP_AND:  w = {OPC_R, rs, rt, rd, 5'd0, FN_AND};
         OP_OR:   w = {OPC_R, rs, rt, rd, 5'd0, FN_OR};
         OP_SLT:  w = {OPC_R, rs, rt, rd, 5'd0, FN_SLT};
         OP_JR:   w = {OPC_R, rs, 15'd0, FN_JR};
         OP_BEQ:  w = {OPC_BEQ, rs, rt, imm[15:0]};
         OP_BNE:  w = {OPC_BNE, rs, rt, imm[15:0]};
         OP_LW:   w = {OPC_LW, rs, rt, imm[15:0]};
         OP_SW:   w = {OPC_SW, rs, rt, imm[15:0]};
         OP_ADDI: w = {OPC_ADDI, rs, rt, imm[15:0]};
         OP_ORI:  w = {OPC_ORI, rs, rt, imm[15:0]};
         OP_J:    w = {OPC_J, target};
         OP_JAL:  w = {OPC_JAL, target};
         default: w = 32'h0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words between request acceptance and the memory write port.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the head is only consumed when the count says it is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into MIPS words and streams them into instruction memory.
// Optional immediate/rd range checking is compiled in with INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [31:0]       req_imm,
   input  logic [25:0]       req_target,
   input  logic              restart,
   input  logic [ADDR_W-1:0] restart_addr,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              mem_full,
   output logic              err
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mem_full_q, mem_full_d;
   logic              err_q, err_d;

   logic        fifo_full, fifo_empty;
   logic [31:0] fifo_head, enc_word;
   logic        accept, push, wr_done;
   logic        illegal, range_bad, rd_zero;

   // Both ports transfer on a rising edge where valid and ready are both high; the sender
   // holds its payload stable while valid is high and ready is low.
   assign req_ready = rst_n && !fifo_full && !mem_full_q && !restart;
   assign accept    = req_valid && req_ready;

   assign illegal  = (req_op == OP_ILLEGAL);
   assign enc_word = encode(req_op, req_rs, req_rt, req_rd, req_imm, req_target);

`ifdef INSTR_ENC_RANGE_CHECK_EN
   always_comb begin
      range_bad = 1'b0;
      if (is_signed_imm(req_op))
         range_bad = !((&req_imm[31:15]) || !(|req_imm[31:15]));
      else if (req_op == OP_ORI)
         range_bad = |req_imm[31:16];
      rd_zero = is_alu_rtype(req_op) && (req_rd == 5'd0);
   end
`else
   assign range_bad = 1'b0;
   assign rd_zero   = 1'b0;
`endif

   // rd=0 is only flagged; the word is still written.
   assign push    = accept && !illegal && !range_bad;
   assign imem_we = !fifo_empty && !mem_full_q;
   assign wr_done = imem_we && imem_ready && !restart;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (restart),
      .push  (push),
      .wdata (enc_word),
      .pop   (wr_done),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      addr_d     = addr_q;
      mem_full_d = mem_full_q;
      err_d      = accept && (illegal || range_bad || rd_zero);
      if (restart) begin
         addr_d     = restart_addr;
         mem_full_d = 1'b0;
      end else if (wr_done) begin
         // The top address is written once and then the port parks there.
         if (addr_q == '1) mem_full_d = 1'b1;
         else              addr_d     = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q     <= '0;
         mem_full_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         mem_full_q <= mem_full_d;
         err_q      <= err_d;
      end
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;
   assign mem_full   = mem_full_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table plus hand-written stall, wrap, restart and reset sequences.
`timescale 1ns/1ps
module tb_instr_encoder;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [3:0]        req_op = 4'd14;
   logic [4:0]        req_rs = '0, req_rt = '0, req_rd = '0;
   logic [31:0]       req_imm = '0;
   logic [25:0]       req_target = '0;
   logic              restart = 1'b0;
   logic [ADDR_W-1:0] restart_addr = '0;
   logic              imem_we;
   logic              imem_ready = 1'b1;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              mem_full;
   logic              err;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_rs       (req_rs),
      .req_rt       (req_rt),
      .req_rd       (req_rd),
      .req_imm      (req_imm),
      .req_target   (req_target),
      .restart      (restart),
      .restart_addr (restart_addr),
      .imem_we      (imem_we),
      .imem_ready   (imem_ready),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .mem_full     (mem_full),
      .err          (err)
   );

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [31:0] imm;
      logic [25:0] tgt;
      logic [31:0] word;
   } vec_t;

   vec_t vecs [14];

   logic [ADDR_W+31:0] exp_q[$];
   logic [ADDR_W+31:0] mon_e;
   logic [ADDR_W-1:0]  push_addr = '0;
   int                 n_vec = 0;
   int                 n_err = 0;
   bit                 rand_ready = 0;
   bit                 acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every completed write must match the oldest expected {addr, word}.
   always @(negedge clk) begin
      if (rst_n && !restart && imem_we && imem_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("imem_write", {imem_addr, imem_wdata}, mon_e);
         end
      end
   end

   // Caller is aligned just after a rising edge; returns just after the edge that ended the attempt.
   task automatic send_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt,
                           input bit exp_push, input logic [31:0] word, input int budget,
                           output bit accepted);
      req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
      req_valid = 1'b1;
      accepted  = 1'b0;
      for (int i = 0; i < budget && !accepted; i++) begin
         if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (req_ready) begin
            accepted = 1'b1;
            if (exp_push) begin
               exp_q.push_back({push_addr, word});
               push_addr = push_addr + 1'b1;
            end
         end
         sync();
      end
      req_valid = 1'b0;
   endtask

   task automatic req_ok(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt,
                         input bit exp_push, input logic [31:0] word);
      bit a;
      send_req(op, rs, rt, rd, imm, tgt, exp_push, word, 60, a);
      check("accepted", a, 1'b1);
   endtask

   task automatic do_restart(input logic [ADDR_W-1:0] a);
      restart = 1'b1;
      restart_addr = a;
      @(negedge clk);
      check("ready_in_restart", req_ready, 1'b0);
      sync();
      restart = 1'b0;
      exp_q.delete();
      push_addr = a;
      @(negedge clk);
      check("restart_addr", imem_addr, a);
      check("restart_we", imem_we, 1'b0);
      sync();
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{4'd1,  5'd4,  5'd5,  5'd6,  32'h0,        26'h0,       32'h00853022};
      vecs[1]  = '{4'd2,  5'd7,  5'd8,  5'd9,  32'h0,        26'h0,       32'h00E84824};
      vecs[2]  = '{4'd3,  5'd10, 5'd11, 5'd12, 32'h0,        26'h0,       32'h014B6025};
      vecs[3]  = '{4'd4,  5'd1,  5'd2,  5'd31, 32'h0,        26'h0,       32'h0022F82A};
      vecs[4]  = '{4'd5,  5'd31, 5'd5,  5'd6,  32'h1234,     26'h0,       32'h03E00008};
      vecs[5]  = '{4'd6,  5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 26'h0,       32'h1022FFFF};
      vecs[6]  = '{4'd7,  5'd3,  5'd4,  5'd0,  32'h10,       26'h0,       32'h14640010};
      vecs[7]  = '{4'd8,  5'd29, 5'd8,  5'd0,  32'h4,        26'h0,       32'h8FA80004};
      vecs[8]  = '{4'd9,  5'd29, 5'd9,  5'd0,  32'h8,        26'h0,       32'hAFA90008};
      vecs[9]  = '{4'd11, 5'd0,  5'd1,  5'd0,  32'hFFFF,     26'h0,       32'h3401FFFF};
      vecs[10] = '{4'd12, 5'd0,  5'd0,  5'd0,  32'h0,        26'h3FFFFFF, 32'h0BFFFFFF};
      vecs[11] = '{4'd14, 5'd7,  5'd7,  5'd7,  32'h55,       26'h123,     32'h00000000};
      vecs[12] = '{4'd0,  5'd1,  5'd2,  5'd3,  32'h0,        26'h0,       32'h00221820};
      vecs[13] = '{4'd10, 5'd1,  5'd2,  5'd0,  32'h5,        26'h0,       32'h20220005};

      // Reset state, with a request pending to show ready is held low.
      req_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", req_ready, 1'b0);
      check("rst_we", imem_we, 1'b0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_mem_full", mem_full, 1'b0);
      check("rst_err", err, 1'b0);
      sync();
      req_valid = 1'b0;
      rst_n = 1'b1;
      sync();

      // ADDI: write appears the cycle after acceptance, then the address advances.
      req_ok(4'd10, 5'd1, 5'd2, 5'd0, 32'h5, 26'h0, 1'b1, 32'h20220005);
      @(negedge clk);
      check("addi_we", imem_we, 1'b1);
      check("addi_word", {imem_addr, imem_wdata}, {8'h00, 32'h20220005});
      check("addi_err", err, 1'b0);
      sync();
      @(negedge clk);
      check("addi_addr_next", imem_addr, 8'h01);
      check("addi_we_idle", imem_we, 1'b0);
      sync();

      // ADD then JAL, back to back from address 0.
      do_restart(8'h00);
      req_ok(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 1'b1, 32'h00221820);
      req_ok(4'd13, 5'd0, 5'd0, 5'd0, 32'h0, 26'h10, 1'b1, 32'h0C000010);
      drain();

      // Illegal op: consumed, not written, err for exactly one cycle.
      req_ok(4'd15, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("illegal_err", err, 1'b1);
      check("illegal_we", imem_we, 1'b0);
      sync();
      @(negedge clk);
      check("illegal_err_drop", err, 1'b0);
      sync();

      // Out-of-range ADDI immediate.
`ifdef INSTR_ENC_RANGE_CHECK_EN
      req_ok(4'd10, 5'd1, 5'd2, 5'd0, 32'h00018000, 26'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("range_err", err, 1'b1);
      check("range_we", imem_we, 1'b0);
      sync();
`else
      req_ok(4'd10, 5'd1, 5'd2, 5'd0, 32'h00018000, 26'h0, 1'b1, 32'h20228000);
      @(negedge clk);
      check("trunc_err", err, 1'b0);
      sync();
`endif
      drain();

      // Stalled memory: only DEPTH requests fit; head holds steady until released.
      do_restart(8'h20);
      imem_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         req_ok(4'd11, 5'd0, 5'(k), 5'd0, 32'(k * 16'h1111), 26'h0, 1'b1,
                32'h34000000 | (32'(k) << 16) | 32'(k * 16'h1111));
      send_req(4'd14, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b1, 32'h0, 3, acc);
      check("fifth_rejected", acc, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_ready", req_ready, 1'b0);
         check("stall_we", imem_we, 1'b1);
         check("stall_head", {imem_addr, imem_wdata}, exp_q[0]);
         sync();
      end
      imem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("burst_we", imem_we, 1'b1);
         sync();
      end
      @(negedge clk);
      check("burst_done_we", imem_we, 1'b0);
      check("burst_done_q", exp_q.size(), 0);
      sync();

      // Top of memory: FE and FF written, third word parked, port halted.
      do_restart(8'hFE);
      for (int k = 0; k < 3; k++)
         req_ok(4'd14, 5'd3, 5'd4, 5'd5, 32'h77, 26'h9, 1'b1, 32'h0);
      @(negedge clk);
      check("full_flag", mem_full, 1'b1);
      check("full_we", imem_we, 1'b0);
      check("full_addr", imem_addr, 8'hFF);
      check("full_ready", req_ready, 1'b0);
      check("full_pending", exp_q.size(), 1);
      sync();
      do_restart(8'h00);
      @(negedge clk);
      check("unfull_flag", mem_full, 1'b0);
      check("unfull_ready", req_ready, 1'b1);
      sync();

      // Vector table with a randomly stalling memory.
      do_restart(8'h40);
      rand_ready = 1'b1;
      for (int i = 0; i < 14; i++)
         req_ok(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt,
                1'b1, vecs[i].word);
      rand_ready = 1'b0;
      imem_ready = 1'b1;
      drain();

      // Reset while a write is stalled abandons it.
      imem_ready = 1'b0;
      req_ok(4'd10, 5'd1, 5'd2, 5'd0, 32'h5, 26'h0, 1'b1, 32'h20220005);
      @(negedge clk);
      check("pre_rst_we", imem_we, 1'b1);
      sync();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", req_ready, 1'b0);
      sync();
      rst_n = 1'b1;
      exp_q.delete();
      push_addr = '0;
      @(negedge clk);
      check("post_rst_we", imem_we, 1'b0);
      check("post_rst_addr", imem_addr, 0);
      sync();
      imem_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_empty", imem_we, 1'b0);
         sync();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
